irq_request_capture: RTL

Request capture stage that sits directly upstream of the 4-input priority encoder and drives its `d[0:3]` request vector. It synchronises asynchronous request lines and converts each rising edge into a sticky pending bit. The pending bit is held until the downstream consumer acknowledges it by index. The block also provides per-line masking and sticky overflow flags for edges that arrive while a line is already pending.

---
 rtl/irq_request_capture.sv | 87 ++++++++
 1 files changed

// File: rtl/irq_request_capture.sv
// Request capture stage feeding the priority encoder: synchronises raw request
// lines, turns rising edges into sticky pending bits, and flags lost edges.
module irq_request_capture #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:N-1]  req_in,
  input  logic [0:N-1]  mask,
  input  logic          ack,
  input  logic [IW-1:0] ack_idx,
  input  logic          clr_ovf,
  output logic [0:N-1]  pend,
  output logic          any_pend,
  output logic [0:N-1]  ovf
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

  logic [0:N-1][SYNC_STAGES-1:0] sync_q;
  logic [0:N-1]                  hist_q;
  logic [0:N-1]                  ovf_q;
  logic [0:N-1]                  ovf_d;
  state_e                        state_q [N];
  state_e                        state_d [N];
  logic [0:N-1]                  rise;
  logic [0:N-1]                  ack_hit;
  logic [0:N-1]                  pending;

  always_comb begin
    rise    = '0;
    ack_hit = '0;
    for (int i = 0; i < N; i++) begin
      rise[i]    = sync_q[i][SYNC_STAGES-1] & ~hist_q[i];
      ack_hit[i] = ack && (ack_idx == IW'(i));
    end
  end

  // Synchroniser chain plus history flop per line; overflow flags live here too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req_in[i]};
        hist_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
    end
  end

  // A rise coinciding with a matching ack keeps the line pending so no edge is lost.
  always_comb begin
    ovf_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (rise[i]) state_d[i] = PENDING;
        PENDING: if (ack_hit[i] && !rise[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
      ovf_d[i] = (ovf_q[i] & ~clr_ovf)
               | (rise[i] & (state_q[i] == PENDING) & ~ack_hit[i]);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < N; i++) pending[i] = (state_q[i] == PENDING);
    pend     = pending & ~mask;
    any_pend = |pend;
    ovf      = ovf_q;
  end

endmodule
